// File: rtl/pc_ctrl.sv
// Program counter and instruction fetch controller: issues one fetch at a time,
// parks a returned word while stalled, and applies prioritised redirects.
module pc_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        trap,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misaligned
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] pc, pc_d, pc_inc;
  logic            kill, kill_d;
  logic [XLEN-1:0] buf_word, buf_word_d;
  logic [XLEN-1:0] buf_pc, buf_pc_d;
  logic [XLEN-1:0] instr_d, instr_pc_d;
  logic            instr_valid_d, misaligned_d;

  logic            redir, mis_tgt;
  logic [XLEN-1:0] sel_tgt, redir_pc;

  // Redirect decode: trap beats jump beats branch; bad alignment diverts to trap.
  always_comb begin
    redir    = trap | jump | branch_taken;
    sel_tgt  = jump ? jump_target : branch_target;
    mis_tgt  = !trap && (jump || branch_taken) && (sel_tgt[1:0] != 2'b00);
    redir_pc = (trap || mis_tgt) ? TRAP_VECTOR : sel_tgt;
    pc_inc   = pc + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_REQ;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_REQ:  if (!redir && !stall) state_d = ST_WAIT;
      ST_WAIT: if (imem_ack) state_d = (redir || kill || !stall) ? ST_REQ : ST_HOLD;
      ST_HOLD: if (redir || !stall) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
  end

  // Fetch request, delivery and hold-buffer control.
  always_comb begin
    pc_d          = pc;
    kill_d        = kill;
    buf_word_d    = buf_word;
    buf_pc_d      = buf_pc;
    instr_d       = instr;
    instr_pc_d    = instr_pc;
    instr_valid_d = 1'b0;
    misaligned_d  = mis_tgt;
    imem_req      = 1'b0;
    imem_addr     = pc;
    case (state)
      ST_REQ: imem_req = reset && !stall && !redir;
      ST_WAIT: begin
        if (redir) begin
          // An in-flight response must be dropped when it finally arrives.
          kill_d = !imem_ack;
        end else if (imem_ack) begin
          if (kill) begin
            kill_d = 1'b0;
          end else if (!stall) begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
            pc_d          = pc_inc;
          end else begin
            buf_word_d = imem_rdata;
            buf_pc_d   = pc;
          end
        end
      end
      ST_HOLD: begin
        if (!redir && !stall) begin
          instr_d       = buf_word;
          instr_pc_d    = buf_pc;
          instr_valid_d = 1'b1;
          pc_d          = pc_inc;
        end
      end
      default: ;
    endcase
    if (redir) pc_d = redir_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_VECTOR;
      kill        <= 1'b0;
      buf_word    <= '0;
      buf_pc      <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      pc          <= pc_d;
      kill        <= kill_d;
      buf_word    <= buf_word_d;
      buf_pc      <= buf_pc_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= instr_valid_d;
      misaligned  <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios with literal expectations, then random
// traffic, all continuously compared against a transaction-level model.
module tb_pc_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, stall, trap, jump, branch_taken, imem_ack;
  logic [31:0] jump_target, branch_target, imem_rdata;
  logic        imem_req, instr_valid, misaligned;
  logic [31:0] imem_addr, instr, instr_pc;

  int n_cmp = 0;
  int n_bad = 0;

  pc_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .reset(reset), .stall(stall), .trap(trap),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding fetch at a time, a queue for a parked word, a kill mark.
  bit          m_known = 1'b0;
  bit          m_busy, m_kill;
  logic [63:0] m_hold[$];
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_mis;
  logic        e_req, e_redir;
  logic [31:0] e_tgt;
  logic [63:0] e_ent;

  always @(negedge clk) begin
    e_redir = trap | jump | branch_taken;
    if (m_known) begin
      e_req = reset && !m_busy && (m_hold.size() == 0) && !stall && !e_redir;
      chk("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("misaligned", 32'(misaligned), 32'(m_mis));
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
    end
    if (!reset) begin
      m_known = 1'b1;
      m_pc = RV; m_busy = 1'b0; m_kill = 1'b0; m_hold.delete();
      m_valid = 1'b0; m_mis = 1'b0; m_instr = '0; m_ipc = '0;
    end else if (m_known) begin
      e_tgt   = jump ? jump_target : branch_target;
      m_mis   = (jump || branch_taken) && !trap && (e_tgt[1:0] != 2'b00);
      m_valid = 1'b0;
      if (e_redir) begin
        m_pc = (trap || m_mis) ? TV : e_tgt;
        m_hold.delete();
        if (m_busy && !imem_ack) m_kill = 1'b1;
        else begin m_busy = 1'b0; m_kill = 1'b0; end
      end else if (m_busy && imem_ack) begin
        m_busy = 1'b0;
        if (m_kill) m_kill = 1'b0;
        else if (stall) m_hold.push_back({imem_rdata, m_pc});
        else begin
          m_valid = 1'b1; m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
        end
      end else if (m_hold.size() > 0) begin
        if (!stall) begin
          e_ent = m_hold.pop_front();
          m_valid = 1'b1; m_instr = e_ent[63:32]; m_ipc = e_ent[31:0]; m_pc = m_pc + 32'd4;
        end
      end else if (!m_busy && !stall) begin
        m_busy = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom;
    case ($urandom_range(0, 7))
      0:       t = 32'hFFFF_FFFC;
      1, 2:    ;
      default: t[1:0] = 2'b00;
    endcase
    return t;
  endfunction

  initial begin
    reset = 1'b0; stall = 1'b0; trap = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    imem_ack = 1'b0; jump_target = '0; branch_target = '0; imem_rdata = '0;
    cyc(); cyc(); cyc();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    reset = 1'b1; #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RV);

    // Zero-wait acks: a delivery every second cycle.
    for (int i = 0; i < 3; i++) begin
      chk("seq_req", 32'(imem_req), 32'd1);
      chk("seq_addr", imem_addr, 32'(4 * i));
      cyc(); imem_ack = 1'b1; imem_rdata = 32'h11 * 32'(i + 1); #1;
      chk("seq_gap", 32'(instr_valid), 32'd0);
      cyc(); imem_ack = 1'b0; #1;
      chk("seq_valid", 32'(instr_valid), 32'd1);
      chk("seq_instr", instr, 32'h11 * 32'(i + 1));
      chk("seq_ipc", instr_pc, 32'(4 * i));
    end

    // Delayed ack during stall parks the word until stall drops.
    chk("hold_addr", imem_addr, 32'h0000_000C);
    cyc(); cyc(); cyc();
    imem_ack = 1'b1; imem_rdata = 32'hA5A5_0001; stall = 1'b1;
    cyc(); imem_ack = 1'b0; #1;
    chk("hold_a_valid", 32'(instr_valid), 32'd0);
    chk("hold_a_req", 32'(imem_req), 32'd0);
    cyc(); stall = 1'b0; #1;
    chk("hold_b_valid", 32'(instr_valid), 32'd0);
    chk("hold_b_req", 32'(imem_req), 32'd0);
    cyc();
    chk("hold_valid", 32'(instr_valid), 32'd1);
    chk("hold_instr", instr, 32'hA5A5_0001);
    chk("hold_ipc", instr_pc, 32'h0000_000C);
    chk("hold_next", imem_addr, 32'h0000_0010);

    // Jump while waiting kills the in-flight response.
    cyc(); jump = 1'b1; jump_target = 32'h40; #1;
    chk("jmp_req", 32'(imem_req), 32'd0);
    cyc(); jump = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_DEAD;
    cyc(); imem_ack = 1'b0; #1;
    chk("kill_valid", 32'(instr_valid), 32'd0);
    chk("kill_req", 32'(imem_req), 32'd1);
    chk("kill_addr", imem_addr, 32'h40);

    // Misaligned branch diverts to trap vector; trap outranks jump.
    branch_taken = 1'b1; branch_target = 32'h42; #1;
    chk("br_req", 32'(imem_req), 32'd0);
    cyc(); branch_taken = 1'b0; #1;
    chk("mis_pulse", 32'(misaligned), 32'd1);
    chk("mis_addr", imem_addr, TV);
    trap = 1'b1; jump = 1'b1; jump_target = 32'h200; #1;
    cyc(); trap = 1'b0; jump = 1'b0; #1;
    chk("trap_mis", 32'(misaligned), 32'd0);
    chk("trap_req", 32'(imem_req), 32'd1);
    chk("trap_addr", imem_addr, TV);

    // PC wrap past the top of the address space.
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    cyc(); jump = 1'b0; #1;
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    cyc(); imem_ack = 1'b1; imem_rdata = 32'h46;
    cyc(); imem_ack = 1'b0; #1;
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset mid-wait; a late ack afterwards is ignored.
    cyc(); reset = 1'b0; #1;
    chk("rstw_req", 32'(imem_req), 32'd0);
    cyc(); reset = 1'b1; stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0BAD;
    cyc(); imem_ack = 1'b0; stall = 1'b0; #1;
    chk("late_valid", 32'(instr_valid), 32'd0);
    chk("late_req", 32'(imem_req), 32'd1);
    chk("late_addr", imem_addr, RV);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      cyc();
      reset         = ($urandom_range(0, 299) != 0);
      stall         = ($urandom_range(0, 9) < 3);
      trap          = ($urandom_range(0, 49) == 0);
      jump          = ($urandom_range(0, 24) == 0);
      branch_taken  = ($urandom_range(0, 24) == 0);
      jump_target   = rand_tgt();
      branch_target = rand_tgt();
      imem_ack      = m_busy ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 29) == 0);
      imem_rdata    = $urandom;
    end
    cyc();
    reset = 1'b1; stall = 1'b0; trap = 1'b0; jump = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
